// File: rtl/ps2_rx_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, error-code bit
// positions, frame length and the default timeout.
package ps2_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_PUSH   = 3'd4
    } ps2_state_e;

    localparam int ERR_PARITY             = 0;
    localparam int ERR_STOP               = 1;
    localparam int ERR_BITS               = 2;
    localparam int FRAME_BITS             = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

    // Value the parity bit must carry so that data plus parity has odd weight.
    function automatic logic odd_parity_bit(input logic [FRAME_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; the head
// entry reads as zero while empty. Shared by the PS/2 receive and transmit paths.
module ps2_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_en, rd_en;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en   = push_i & (~full_o | pop_i);
    assign rd_en   = pop_i & ~empty_o;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: storage has no reset; the empty mask above hides stale entries, and
    // leaving the array unreset lets it map onto plain RAM cells.
    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    // NOTE: state registers use <= so every flop samples pre-edge values,
    // independent of the order the simulator evaluates blocks in.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: synchronise, decode 11-bit frames, queue
// {err, byte} in a FWFT FIFO. Define PS2_RX_DEGLITCH_EN to add input filters.
module ps2_rx_buffered
    import ps2_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          CLK_PS2_IN,
    input  logic                          DATA_PS2_IN,
    input  logic                          READ_ENABLE,
    output logic [7:0]                    BYTE_DATA,
    output logic [1:0]                    BYTE_ERR,
    output logic                          BYTE_VALID,
    input  logic                          BYTE_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERFLOW,
    output logic                          FRAME_ABORT
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BC_W = $clog2(FRAME_BITS);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_PARITY = ST_PARITY;
    localparam logic [2:0] S_STOP   = ST_STOP;
    localparam logic [2:0] S_PUSH   = ST_PUSH;

    if (FILTER_LEN < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
        $error("ps2_rx_buffered: bad FILTER_LEN or FIFO_DEPTH");
    end

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic clk_f, dat_f, clk_prev_q, fall;

    // Idle PS/2 lines float high; resetting high avoids a spurious edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            {clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q, clk_prev_q} <= '1;
        end else begin
            clk_s1_q   <= CLK_PS2_IN;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= DATA_PS2_IN;
            dat_s2_q   <= dat_s1_q;
            clk_prev_q <= clk_f;
        end
    end

`ifdef PS2_RX_DEGLITCH_EN
    localparam int FC_W = $clog2(FILTER_LEN + 1);
    logic [FC_W-1:0] clk_fc_q, dat_fc_q;
    logic            clk_f_q, dat_f_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            {clk_f_q, dat_f_q} <= '1;
            clk_fc_q <= '0;
            dat_fc_q <= '0;
        end else begin
            if (clk_s2_q == clk_f_q)                 clk_fc_q <= '0;
            else if (clk_fc_q == FC_W'(FILTER_LEN-1)) begin clk_f_q <= clk_s2_q; clk_fc_q <= '0; end
            else                                     clk_fc_q <= clk_fc_q + FC_W'(1);
            if (dat_s2_q == dat_f_q)                 dat_fc_q <= '0;
            else if (dat_fc_q == FC_W'(FILTER_LEN-1)) begin dat_f_q <= dat_s2_q; dat_fc_q <= '0; end
            else                                     dat_fc_q <= dat_fc_q + FC_W'(1);
        end
    end

    assign clk_f = clk_f_q;
    assign dat_f = dat_f_q;
`else
    assign clk_f = clk_s2_q;
    assign dat_f = dat_s2_q;
`endif

    assign fall = clk_prev_q & ~clk_f;

    logic [2:0]            state_q, state_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [ERR_BITS-1:0]   err_q, err_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  abort_q, abort_d, push, pop, fifo_full;
    logic                  ovf_q;
    logic [ERR_BITS+FRAME_BITS-1:0] head;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        err_d     = err_q;
        to_cnt_d  = fall ? '0 : to_cnt_q + TO_W'(1);
        abort_d   = 1'b0;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (fall && !dat_f && READ_ENABLE) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    err_d     = '0;
                end
            end
            S_DATA: if (fall) begin
                shift_d = {dat_f, shift_q[FRAME_BITS-1:1]};
                if (bit_cnt_q == BC_W'(FRAME_BITS-1)) state_d = S_PARITY;
                else                                  bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
            S_PARITY: if (fall) begin
                err_d[ERR_PARITY] = (dat_f != odd_parity_bit(shift_q));
                state_d           = S_STOP;
            end
            S_STOP: if (fall) begin
                err_d[ERR_STOP] = ~dat_f;
                state_d         = S_PUSH;
            end
            S_PUSH: begin
                push    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A falling edge in the expiry cycle keeps the frame alive.
        if ((state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP) &&
            !fall && to_cnt_q == TO_W'(TIMEOUT_CYCLES-1)) begin
            state_d = S_IDLE;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            err_q     <= '0;
            to_cnt_q  <= '0;
            abort_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
            abort_q   <= abort_d;
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    assign pop = BYTE_VALID & BYTE_READY;

    ps2_rx_fifo #(
        .WIDTH (ERR_BITS + FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({err_q, shift_q}),
        .rdata_o (head),
        .count_o (FIFO_COUNT),
        .full_o  (fifo_full),
        .empty_o ()
    );

    assign BYTE_VALID  = (FIFO_COUNT != '0);
    assign BYTE_DATA   = head[FRAME_BITS-1:0];
    assign BYTE_ERR    = head[ERR_BITS+FRAME_BITS-1:FRAME_BITS];
    assign OVERFLOW    = ovf_q;
    assign FRAME_ABORT = abort_q;

endmodule

// File: doc/ps2_rx_buffered.md
# ps2_rx_buffered

Parametrised PS/2 device-to-host receiver: the next generation of the mouse byte receiver. Decodes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) into bytes and queues them, each with a per-byte error code, in an internal first-word-fall-through FIFO with a valid/ready pop handshake. Unlike the previous receiver, it synchronises the PS/2 inputs, makes the timeout configurable, checks the stop bit, reports aborted frames, and absorbs bursts without the consumer reacting in one cycle. Sits between the PS/2 pads and the mouse/keyboard transceiver FSM.

## Interface
- TIMEOUT_CYCLES, 100000: CLK cycles without a PS/2 falling edge before a frame in progress is abandoned (1 ms at 100 MHz).
- FIFO_DEPTH, 4: byte-queue entries; power of two, ≥2.
- FILTER_LEN, 4: deglitch stability length in CLK cycles; only used with PS2_RX_DEGLITCH_EN.
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- CLK_PS2_IN  in  1  raw PS/2 clock line.
- DATA_PS2_IN  in  1  raw PS/2 data line.
- READ_ENABLE  in  1  gates detection of new start bits only.
- BYTE_DATA  out  8  head-of-FIFO byte; 8'h00 when empty.
- BYTE_ERR  out  2  head-of-FIFO error code: [0] parity error, [1] stop bit low; 2'b00 when empty.
- BYTE_VALID  out  1  FIFO non-empty.
- BYTE_READY  in  1  consumer accepts; pop when BYTE_VALID & BYTE_READY.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- OVERFLOW  out  1  sticky: a completed byte was dropped because the FIFO was full; cleared only by RESET.
- FRAME_ABORT  out  1  one-cycle pulse when a frame is abandoned on timeout.

## Operation
- Both PS/2 inputs pass through a 2-flop synchroniser. A falling edge is registered previous-synced-clock = 1 and current = 0.
- FSM states: IDLE, DATA, PARITY, STOP, PUSH.
- IDLE: on a falling edge with sync data = 0 and READ_ENABLE = 1 → DATA; clear the bit counter, shift register and error code. A falling edge with data = 1 is ignored.
- DATA: on each falling edge, shift data into bit 7 and shift right (LSB first). After the 8th edge → PARITY.
- PARITY: on the falling edge, err[0] = (data != ~^shift) → STOP.
- STOP: on the falling edge, err[1] = (data == 0) → PUSH.
- PUSH: one cycle. Write {err, shift} to the FIFO → IDLE.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). It clears on every falling edge and in IDLE, and increments otherwise.
  - In DATA, PARITY or STOP, reaching TIMEOUT_CYCLES-1 → IDLE, pulse FRAME_ABORT, no push.
  - A timeout and a falling edge in the same cycle: the edge wins.
- READ_ENABLE falling mid-frame does not abort the frame.
- FIFO write is accepted if not full, or if full with a pop in the same cycle. Otherwise the byte is dropped and OVERFLOW is set.
- Pop on an empty FIFO is ignored. Simultaneous push and pop leaves FIFO_COUNT unchanged.
- Pointers wrap modulo FIFO_DEPTH. There is an extra occupancy bit, so full = FIFO_DEPTH and is distinguished from empty.

## Timing
- Reset values:
  - state IDLE, all counters 0.
  - BYTE_VALID 0, BYTE_DATA 8'h00, BYTE_ERR 2'b00.
  - FIFO_COUNT 0, OVERFLOW 0, FRAME_ABORT 0.
- RESET mid-frame discards the partial frame and FIFO contents, with no FRAME_ABORT pulse.
- Edge-detect latency: 3 CLK cycles from the raw pin edge, without the filter.
- Stop-bit edge detected in cycle N → PUSH in N+1 → BYTE_VALID/BYTE_DATA updated in N+2 (if the FIFO was empty).
- FWFT: the pop in cycle M presents the next entry in M+1. BYTE_VALID is combinational from the count register.

## Configuration
- PS2_RX_DEGLITCH_EN defined:
  - The synced clock and data each feed a stability filter.
  - The filtered output changes only after FILTER_LEN consecutive equal samples.
  - Edge-detect latency becomes 3+FILTER_LEN cycles.
  - Pulses shorter than FILTER_LEN cycles are never seen.
- Not defined: 2-flop synchroniser only; FILTER_LEN unused; no filter logic.

## Structure
- Package ps2_rx_pkg:
  - FSM state enum.
  - ERR_PARITY=0 and ERR_STOP=1 bit indices.
  - Default TIMEOUT_CYCLES constant.
  - Frame length constant (8 data bits).
- Sub-module ps2_rx_fifo: synchronous FWFT FIFO.
  - Parameters WIDTH=10, DEPTH.
  - Ports push/pop/data/count/full/empty.
  - Reused later by the transmit path.

## Test plan
- Frame 0x5A with parity 1 (correct odd parity), stop 1, READ_ENABLE=1 → BYTE_VALID rises 2 cycles after the stop edge; BYTE_DATA=8'h5A, BYTE_ERR=2'b00.
- Frame 0x5A with parity 0 and stop 0 → BYTE_ERR=2'b11.
- Five frames 0x01–0x05 with BYTE_READY=0 and FIFO_DEPTH=4:
  - FIFO_COUNT=4 and OVERFLOW=1.
  - Draining yields 0x01..0x04; 0x05 is lost.
- Clock stops after 4 data bits for TIMEOUT_CYCLES (test value 200) → FRAME_ABORT pulses once, state returns to IDLE, no push; the next full frame 0xC3 is received correctly.
- Full FIFO with BYTE_READY=1 held while a new frame completes → the push is accepted, FIFO_COUNT stays 4, OVERFLOW stays 0.
- With PS2_RX_DEGLITCH_EN and FILTER_LEN=4: inject 2-cycle low glitches on the PS/2 clock line during IDLE → no start detected, BYTE_VALID stays 0.
